// File: rtl/mmio_tx.sv
// Memory-mapped serial transmitter: a store window feeding a byte FIFO that drains as 8N1 frames.
// Define MMIO_TX_PARITY_EN to compile in an even-parity bit (8E1 frames).
module mmio_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_FF00,
  parameter int          FIFO_DEPTH   = 8,
  parameter int          CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write,
  input  logic [31:0] data_addr,
  input  logic [31:0] write_data,
  output logic        sel,
  output logic [31:0] read_data,
  output logic        tx,
  output logic        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

`ifdef MMIO_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t          state, state_n;
  logic [BW-1:0]   baud, baud_n;
  logic [2:0]      bit_idx, bit_n;
  logic [7:0]      shift, shift_n;
  logic            tx_n;
  logic            pop;
  logic            bit_done;
`ifdef MMIO_TX_PARITY_EN
  logic            parity, parity_n;
`endif

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [CW-1:0]   count;
  logic            overflow;
  logic            full, empty;
  logic            wr, push, ctrl_wr, flush, ovf_clr, push_ok, ovf_set;
  logic            unused_bits;

`ifdef MMIO_TX_PARITY_EN
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction
`endif

  // Bus decode
  assign sel      = (data_addr[31:4] == BASE_ADDR[31:4]);
  assign wr       = mem_write && sel;
  assign push     = wr && (data_addr[3:2] == 2'd0);
  assign ctrl_wr  = wr && (data_addr[3:2] == 2'd2);
  assign flush    = ctrl_wr && write_data[0];
  assign ovf_clr  = ctrl_wr && write_data[1];
  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  // A same-cycle pop frees a slot, so a push into a full FIFO is still accepted then.
  assign push_ok  = push && !flush && (!full || pop);
  assign ovf_set  = push && !flush && full && !pop;
  assign unused_bits = ^{data_addr[1:0], write_data[31:8]};

  always_comb begin
    read_data = '0;
    if (sel && (data_addr[3:2] == 2'd1)) begin
      read_data[0]       = full;
      read_data[1]       = empty;
      read_data[2]       = busy;
      read_data[3]       = overflow;
      read_data[8 +: CW] = count;
    end
  end

  // FIFO state
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (flush) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (push_ok) wptr <= wptr + 1'b1;
        if (pop)     rptr <= rptr + 1'b1;
        case ({push_ok, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: ;
        endcase
      end
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= write_data[7:0];
  end

  // Transmit FSM next state
  always_comb begin
    state_n  = state;
    baud_n   = '0;
    bit_n    = bit_idx;
    shift_n  = shift;
    pop      = 1'b0;
    bit_done = (baud == BAUD_LAST);
`ifdef MMIO_TX_PARITY_EN
    parity_n = parity;
`endif
    if (state != S_IDLE) baud_n = bit_done ? '0 : baud + 1'b1;
    case (state)
      S_IDLE: begin
        if (!empty && !flush) begin
          pop     = 1'b1;
          shift_n = mem[rptr];
          bit_n   = 3'd0;
          state_n = S_START;
`ifdef MMIO_TX_PARITY_EN
          parity_n = even_parity(mem[rptr]);
`endif
        end
      end
      S_START: if (bit_done) state_n = S_DATA;
      S_DATA: begin
        if (bit_done) begin
          shift_n = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) begin
`ifdef MMIO_TX_PARITY_EN
            state_n = S_PARITY;
`else
            state_n = S_STOP;
`endif
          end else begin
            bit_n = bit_idx + 1'b1;
          end
        end
      end
`ifdef MMIO_TX_PARITY_EN
      S_PARITY: if (bit_done) state_n = S_STOP;
`endif
      S_STOP:  if (bit_done) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    // Line level is computed from the next state so tx can be a plain register.
    case (state_n)
      S_START:  tx_n = 1'b0;
      S_DATA:   tx_n = shift_n[0];
`ifdef MMIO_TX_PARITY_EN
      S_PARITY: tx_n = parity_n;
`endif
      default:  tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      baud    <= '0;
      bit_idx <= 3'd0;
      tx      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_n;
      tx      <= tx_n;
      busy    <= (state_n != S_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    shift <= shift_n;
`ifdef MMIO_TX_PARITY_EN
    parity <= parity_n;
`endif
  end

endmodule
